// File: rtl/product_checker.sv
// product_checker: shift-add recompute of the 8/16/32-bit multiplier product, compared against the observed one.
// Latency N+1 cycles from accept (N = operand width); in_ready low while busy, results are never back-pressured.
// Optional PRODUCT_CHECKER_HALT_ON_FAIL_EN: a mismatch blocks further transactions until reset.
module product_checker #(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_mode,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic [63:0]      in_product,
  output logic             res_valid,
  output logic             res_match,
  output logic [63:0]      res_expected,
  output logic [CNT_W-1:0] pass_count,
  output logic [CNT_W-1:0] fail_count,
  output logic             halted
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    CMP  = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic accept;
  logic step;
  logic finish;

  logic [1:0]  mode_q;
  logic [63:0] prod_q;
  logic [63:0] mcand_q;
  logic [31:0] mplier_q;
  logic [63:0] acc_q;
  logic        sign_q;
  logic [5:0]  cnt_q;

  logic [31:0] a_ext;
  logic [31:0] b_ext;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [5:0]  n_bits;
  logic [63:0] acc_sum;
  logic [63:0] expected;
  logic [63:0] cmp_mask;
  logic        match;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Extends the low N operand bits to 32 bits: zero for M1, sign for M2-M4.
  function automatic logic [31:0] ext_op(input logic [1:0] mode, input logic [31:0] v);
    logic [31:0] r;
    r = v;
    case (mode)
      2'd0:    r = {24'd0, v[7:0]};
      2'd1:    r = {{24{v[7]}}, v[7:0]};
      2'd2:    r = {{16{v[15]}}, v[15:0]};
      default: r = v;
    endcase
    return r;
  endfunction

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = MUL;
      MUL:     if (cnt_q == 6'd1) state_nxt = CMP;
      CMP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state == IDLE) && !halted;
    accept   = in_valid && in_ready;
    step     = (state == MUL);
    finish   = (state == CMP);
  end

  always_comb begin
    a_ext = ext_op(in_mode, in_a);
    b_ext = ext_op(in_mode, in_b);
    a_neg = (in_mode != 2'd0) && a_ext[31];
    b_neg = (in_mode != 2'd0) && b_ext[31];
    // -2^31 negates to itself, which is the correct 32-bit unsigned magnitude.
    a_mag = a_neg ? (~a_ext + 32'd1) : a_ext;
    b_mag = b_neg ? (~b_ext + 32'd1) : b_ext;
    case (in_mode)
      2'd0, 2'd1: n_bits = 6'd8;
      2'd2:       n_bits = 6'd16;
      default:    n_bits = 6'd32;
    endcase
  end

  always_comb begin
    acc_sum  = acc_q + (mplier_q[0] ? mcand_q : 64'd0);
    expected = sign_q ? (~acc_q + 64'd1) : acc_q;
    case (mode_q)
      2'd0, 2'd1: cmp_mask = 64'h0000_0000_0000_FFFF;
      2'd2:       cmp_mask = 64'h0000_0000_FFFF_FFFF;
      default:    cmp_mask = 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
    match = ((expected ^ prod_q) & cmp_mask) == 64'd0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      mode_q       <= 2'd0;
      prod_q       <= 64'd0;
      mcand_q      <= 64'd0;
      mplier_q     <= 32'd0;
      acc_q        <= 64'd0;
      sign_q       <= 1'b0;
      cnt_q        <= 6'd0;
      res_valid    <= 1'b0;
      res_match    <= 1'b0;
      res_expected <= 64'd0;
      pass_count   <= '0;
      fail_count   <= '0;
    end else begin
      res_valid <= 1'b0;
      if (accept) begin
        mode_q   <= in_mode;
        prod_q   <= in_product;
        mcand_q  <= {32'd0, a_mag};
        mplier_q <= b_mag;
        sign_q   <= a_neg ^ b_neg;
        acc_q    <= 64'd0;
        cnt_q    <= n_bits;
      end
      if (step) begin
        acc_q    <= acc_sum;
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
        cnt_q    <= cnt_q - 6'd1;
      end
      if (finish) begin
        res_valid    <= 1'b1;
        res_match    <= match;
        res_expected <= expected;
        if (match && pass_count != CNT_MAX)  pass_count <= pass_count + CNT_W'(1);
        if (!match && fail_count != CNT_MAX) fail_count <= fail_count + CNT_W'(1);
      end
    end
  end

`ifdef PRODUCT_CHECKER_HALT_ON_FAIL_EN
  always_ff @(posedge clock) begin
    if (reset)                halted <= 1'b0;
    else if (finish && !match) halted <= 1'b1;
  end
`else
  assign halted = 1'b0;
`endif

endmodule

// File: doc/product_checker.md
# product_checker

Self-checking stage downstream of the multiplier controller. It accepts one operand pair, mode and observed product per handshake and recomputes the expected product with an iterative shift-add multiplier, one operand bit per cycle. It then compares the result against the observed product and reports pass/fail per transaction. Running pass/fail counters give the test harness a hardware scoreboard for the 8/16/32-bit multiplier datapaths.

## Interface
Parameters:
- CNT_W, 16, width of the pass/fail counters.

Ports:
- clock  in  1  single clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  transaction offered.
- in_ready  out  1  checker can accept; combinational, high only in IDLE and not halted.
- in_mode  in  2  0=M1 unsigned 8x8, 1=M2 signed 8x8, 2=M3 signed 16x16, 3=M4 signed 32x32.
- in_a, in_b  in  32  operands; only the low N bits are used (N=8/8/16/32 per mode).
- in_product  in  64  observed product from the multiplier.
- res_valid  out  1  one-cycle pulse per completed check.
- res_match  out  1  valid with res_valid: 1 = observed equals expected.
- res_expected  out  64  expected product, zero-extended (M1) or sign-extended (M2–M4) to 64 bits; holds until the next result.
- pass_count, fail_count  out  CNT_W  saturating counters.
- halted  out  1  sticky fail halt; see Configuration.

## Operation
- States: IDLE, MUL, CMP.
- IDLE, on in_valid && in_ready:
  - latch mode, the low N bits of a/b, and the product;
  - store operand magnitudes (32-bit unsigned; -2^31 → 2^31) and the result sign (XOR of operand signs; 0 in M1);
  - clear the 64-bit accumulator, set bit counter = N, go to MUL.
- in_valid while in_ready=0: ignored, nothing latched. Upstream holds its data.
- MUL, each cycle:
  - if multiplier LSB=1, accumulator += multiplicand;
  - multiplicand <<= 1; multiplier >>= 1; counter -= 1;
  - go to CMP when counter reaches 0 (exactly N MUL cycles).
- CMP:
  - expected = sign ? -acc : acc (64-bit two's complement);
  - compare the low 2N bits of expected and the latched product; product bits above 2N are ignored;
  - register res_valid=1, res_match, res_expected;
  - increment pass_count or fail_count, saturating at 2^CNT_W-1;
  - go to IDLE.
- Input changes after acceptance have no effect.
- Reset (any state, including mid-MUL): state=IDLE, partial work discarded, no res_valid.
- Reset values: in_ready=1, res_valid=0, res_match=0, res_expected=0, pass_count=0, fail_count=0, halted=0.

## Timing
- Accept edge E0. MUL occupies edges E1..EN. CMP registers the result at E(N+1).
- res_valid is high in the cycle after E(N+1): latency N+1 cycles from acceptance.
- in_ready reasserts in the same cycle res_valid is high. Back-to-back throughput is one transaction per N+2 cycles: 10 for M1/M2, 18 for M3, 34 for M4.
- res_valid is never high for more than one cycle. No backpressure on the result side.

## Configuration
- PRODUCT_CHECKER_HALT_ON_FAIL_EN:
  - Defined: a mismatch in CMP sets halted=1 in the same edge as res_valid. While halted, in_ready=0 and no further transactions are accepted. Only reset clears halted.
  - Undefined: halted is tied to 0 and the checker continues after mismatches.

## Test plan
- M1, a=0xFF, b=0xFF, product=0xFE01 → res_valid 9 cycles after accept, res_match=1, res_expected=0x0000_0000_0000_FE01, pass_count=1.
- M2, a=0x80, b=0x7F, product=0xC080 → res_match=1, res_expected=0xFFFF_FFFF_FFFF_C080.
- M4, a=0x8000_0000, b=0x8000_0000, product=0x4000_0000_0000_0000 → res_match=1, latency 33 cycles.
- M3, a=0x0003, b=0xFFFE, product=0x0000_0006 → res_match=0, res_expected=0xFFFF_FFFF_FFFF_FFFA, fail_count=1.
  - With the macro defined: halted=1 and in_ready stays 0 with in_valid held high.
  - With the macro undefined: the next transaction is accepted.
- Reset asserted mid-MUL of an M4 transaction → next cycle in_ready=1, counters 0, no res_valid ever pulses for that transaction.
- in_valid held high with M1 stimulus for 5 transactions, operand changes offered while busy → exactly 5 res_valid pulses, 10 cycles apart, each checking the values present at its accept edge.
